// File: rtl/microcode_sequencer_pkg.sv
// Shared encodings for the microcode sequencer: branch ops, FSM states, mux selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package microcode_sequencer_pkg;

    typedef enum logic [2:0] {
        BR_NEXT  = 3'd0,
        BR_JUMP  = 3'd1,
        BR_JMP_T = 3'd2,
        BR_JMP_F = 3'd3,
        BR_MAP   = 3'd4,
        BR_CALL  = 3'd5,
        BR_RET   = 3'd6,
        BR_HALT  = 3'd7
    } br_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } seq_state_e;

    localparam logic [1:0] SEL_INC  = 2'd0;
    localparam logic [1:0] SEL_JUMP = 2'd1;
    localparam logic [1:0] SEL_MAP  = 2'd2;

endpackage

// File: rtl/microcode_sequencer_mux.sv
// 3-way next micro-address mux: increment, jump target or opcode-mapped entry.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the output is loaded.
// Ports: sel (SEL_*), inc_addr / jump_addr / map_addr candidates, next_addr result.
module mux1_ControlUnit
    import microcode_sequencer_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [1:0]        sel,
    input  logic [ADDR_W-1:0] inc_addr,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic [ADDR_W-1:0] map_addr,
    output logic [ADDR_W-1:0] next_addr
);

    always_comb begin
        case (sel)
            SEL_JUMP: next_addr = jump_addr;
            SEL_MAP:  next_addr = map_addr;
            default:  next_addr = inc_addr;  // SEL_INC and the unused code 3
        endcase
    end

endmodule

// File: rtl/microcode_sequencer.sv
// Control address register (CAR) sequencer with branch decode and a small return-address stack.
// Latency: one microinstruction per cycle; CAR updates on the edge after its inputs settle.
// Backpressure: stall freezes CAR, stack and FSM for the cycle; mux_sel still tracks br_op.
// Ports: start/stall control; br_op, cond_sel, status, br_addr, map_addr from the control store
// and IR; car, mux_sel, running/halted/fault and stack depth out.
module microcode_sequencer
    import microcode_sequencer_pkg::*;
#(
    parameter int                 ADDR_W      = 16,
    parameter int                 STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  START_ADDR  = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             stall,
    input  logic [2:0]                       br_op,
    input  logic [1:0]                       cond_sel,
    input  logic [3:0]                       status,
    input  logic [ADDR_W-1:0]                br_addr,
    input  logic [ADDR_W-1:0]                map_addr,
    output logic [ADDR_W-1:0]                car,
    output logic [1:0]                       mux_sel,
    output logic                             running,
    output logic                             halted,
    output logic                             fault,
    output logic [$clog2(STACK_DEPTH):0]     depth
);

    localparam int PTR_W   = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = PTR_W + 1;

    seq_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  car_q, car_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0]  stack_d [STACK_DEPTH];

    logic [ADDR_W-1:0]  inc_addr;
    logic [ADDR_W-1:0]  jump_addr;
    logic [ADDR_W-1:0]  next_addr;
    logic [PTR_W-1:0]   top_idx;
    logic               stack_full;
    logic               stack_empty;

    assign inc_addr    = car_q + 1'b1;  // wraps at 2^ADDR_W
    // When full, the low bits of depth are zero and the subtraction wraps to the last slot.
    assign top_idx     = depth_q[PTR_W-1:0] - 1'b1;
    assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign stack_empty = (depth_q == '0);

    // Branch decode. Only meaningful in RUN; elsewhere the mux is parked on increment.
    always_comb begin
        mux_sel   = SEL_INC;
        jump_addr = br_addr;
        if (state_q == ST_RUN) begin
            case (br_op_e'(br_op))
                BR_JUMP:  mux_sel = SEL_JUMP;
                BR_JMP_T: mux_sel = status[cond_sel]  ? SEL_JUMP : SEL_INC;
                BR_JMP_F: mux_sel = !status[cond_sel] ? SEL_JUMP : SEL_INC;
                BR_MAP:   mux_sel = SEL_MAP;
                BR_CALL:  mux_sel = SEL_JUMP;
                BR_RET: begin
                    mux_sel   = SEL_JUMP;
                    jump_addr = stack_q[top_idx];
                end
                default:  mux_sel = SEL_INC;  // NEXT, HALT
            endcase
        end
    end

    mux1_ControlUnit #(
        .ADDR_W (ADDR_W)
    ) u_next_mux (
        .sel       (mux_sel),
        .inc_addr  (inc_addr),
        .jump_addr (jump_addr),
        .map_addr  (map_addr),
        .next_addr (next_addr)
    );

    // Next-state, CAR and stack update. Stall blocks every change, including leaving IDLE/HALTED.
    always_comb begin
        state_d = state_q;
        car_d   = car_q;
        depth_d = depth_q;
        stack_d = stack_q;
        case (state_q)
            ST_IDLE: begin
                car_d = START_ADDR;
                if (start && !stall) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!stall) begin
                    case (br_op_e'(br_op))
                        BR_HALT: state_d = ST_HALTED;
                        BR_CALL: begin
                            if (stack_full) begin
                                state_d = ST_FAULT;
                            end else begin
                                stack_d[depth_q[PTR_W-1:0]] = inc_addr;
                                depth_d = depth_q + 1'b1;
                                car_d   = next_addr;
                            end
                        end
                        BR_RET: begin
                            if (stack_empty) begin
                                state_d = ST_FAULT;
                            end else begin
                                depth_d = depth_q - 1'b1;
                                car_d   = next_addr;
                            end
                        end
                        default: car_d = next_addr;
                    endcase
                end
            end
            ST_HALTED: begin
                // Resume at the word after the HALT microinstruction.
                if (start && !stall) begin
                    state_d = ST_RUN;
                    car_d   = inc_addr;
                end
            end
            ST_FAULT: begin
                // Frozen until reset.
            end
            default: begin
                state_d = ST_IDLE;
                car_d   = START_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            car_q   <= START_ADDR;
            depth_q <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            car_q   <= car_d;
            depth_q <= depth_d;
            stack_q <= stack_d;
        end
    end

    assign car     = car_q;
    assign depth   = depth_q;
    assign running = (state_q == ST_RUN);
    assign halted  = (state_q == ST_HALTED);
    assign fault   = (state_q == ST_FAULT);

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed vector table, hand sequences, randomized model run.
// Latency: n/a.
// Backpressure: stall exercised in table and random phases.
module tb_microcode_sequencer;

    localparam int          ADDR_W = 16;
    localparam int          SDEPTH = 4;
    localparam logic [15:0] START  = 16'h0000;

    // Branch codes and modes as plain numbers for the bench's own model.
    localparam logic [2:0] OP_NEXT = 3'd0, OP_JUMP = 3'd1, OP_JT = 3'd2, OP_JF = 3'd3,
                           OP_MAP = 3'd4, OP_CALL = 3'd5, OP_RET = 3'd6, OP_HALT = 3'd7;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;

    logic        clk, rst_n, start, stall;
    logic [2:0]  br_op;
    logic [1:0]  cond_sel;
    logic [3:0]  status;
    logic [15:0] br_addr, map_addr;
    logic [15:0] car;
    logic [1:0]  mux_sel;
    logic        running, halted, fault;
    logic [2:0]  depth;

    int n_tests = 0;
    int n_fail  = 0;

    microcode_sequencer #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (SDEPTH),
        .START_ADDR  (START)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stall    (stall),
        .br_op    (br_op),
        .cond_sel (cond_sel),
        .status   (status),
        .br_addr  (br_addr),
        .map_addr (map_addr),
        .car      (car),
        .mux_sel  (mux_sel),
        .running  (running),
        .halted   (halted),
        .fault    (fault),
        .depth    (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_mode;
    logic [15:0] m_car;
    logic [15:0] m_stack[$];

    function automatic logic [1:0] model_sel(input logic [2:0] op, input logic [1:0] cs,
                                             input logic [3:0] st);
        if (m_mode != M_RUN) return 2'd0;
        case (op)
            OP_JUMP, OP_CALL, OP_RET: return 2'd1;
            OP_JT:  return st[cs] ? 2'd1 : 2'd0;
            OP_JF:  return st[cs] ? 2'd0 : 2'd1;
            OP_MAP: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    task automatic model_step(input logic s, input logic stl, input logic [2:0] op,
                              input logic [1:0] cs, input logic [3:0] st,
                              input logic [15:0] ba, input logic [15:0] ma);
        logic [15:0] nxt;
        nxt = m_car + 16'd1;
        case (m_mode)
            M_IDLE: begin
                m_car = START;
                if (s && !stl) m_mode = M_RUN;
            end
            M_RUN: if (!stl) begin
                case (op)
                    OP_NEXT: m_car = nxt;
                    OP_JUMP: m_car = ba;
                    OP_JT:   m_car = st[cs] ? ba : nxt;
                    OP_JF:   m_car = st[cs] ? nxt : ba;
                    OP_MAP:  m_car = ma;
                    OP_CALL: if (m_stack.size() == SDEPTH) m_mode = M_FAULT;
                             else begin m_stack.push_back(nxt); m_car = ba; end
                    OP_RET:  if (m_stack.size() == 0) m_mode = M_FAULT;
                             else m_car = m_stack.pop_back();
                    default: m_mode = M_HALT;
                endcase
            end
            M_HALT: if (s && !stl) begin
                m_mode = M_RUN;
                m_car  = nxt;
            end
            default: ;
        endcase
    endtask

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge; returns at the next falling edge.
    task automatic drive_cycle(input logic s, input logic stl, input logic [2:0] op,
                               input logic [1:0] cs, input logic [3:0] st,
                               input logic [15:0] ba, input logic [15:0] ma,
                               output logic [1:0] sel_seen);
        start = s; stall = stl; br_op = op; cond_sel = cs; status = st;
        br_addr = ba; map_addr = ma;
        #1;
        sel_seen = mux_sel;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0; stall = 1'b0; br_op = OP_NEXT; cond_sel = '0; status = '0;
        br_addr = '0; map_addr = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_mode = M_IDLE;
        m_car  = START;
        m_stack.delete();
    endtask

    task automatic chk_state(input string name, input logic [15:0] e_car, input logic e_run,
                             input logic e_halt, input logic e_fault, input logic [2:0] e_depth);
        chk({name, ".car"},     car,     e_car);
        chk({name, ".running"}, running, e_run);
        chk({name, ".halted"},  halted,  e_halt);
        chk({name, ".fault"},   fault,   e_fault);
        chk({name, ".depth"},   depth,   e_depth);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string       name;
        logic        s, stl;
        logic [2:0]  op;
        logic [1:0]  cs;
        logic [3:0]  st;
        logic [15:0] ba, ma;
        logic [1:0]  e_sel;
        logic [15:0] e_car;
        logic        e_run, e_halt, e_fault;
        logic [2:0]  e_depth;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input string n, input logic s, input logic stl, input logic [2:0] op,
                        input logic [1:0] cs, input logic [3:0] st, input logic [15:0] ba,
                        input logic [15:0] ma, input logic [1:0] e_sel, input logic [15:0] e_car,
                        input logic e_run, input logic e_halt, input logic [2:0] e_depth);
        vec_t v;
        v.name = n; v.s = s; v.stl = stl; v.op = op; v.cs = cs; v.st = st; v.ba = ba; v.ma = ma;
        v.e_sel = e_sel; v.e_car = e_car; v.e_run = e_run; v.e_halt = e_halt;
        v.e_fault = 1'b0; v.e_depth = e_depth;
        vq.push_back(v);
    endtask

    initial begin
        logic [1:0] sel;
        logic       s, stl;
        logic [2:0] op;
        logic [1:0] cs;
        logic [3:0] st;
        logic [15:0] ba, ma;

        rst_n = 1'b1;
        @(negedge clk);
        do_reset();

        // Reset state.
        #1;
        chk("reset.mux_sel", mux_sel, 2'd0);
        chk_state("reset", START, 1'b0, 1'b0, 1'b0, 3'd0);
        @(negedge clk);

        //    name        s  stl op       cs  status   br_addr   map_addr  sel car       run halt depth
        addv("start",     1, 0, OP_NEXT, 0, 4'b0000, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 0);
        addv("next1",     0, 0, OP_NEXT, 0, 4'b0000, 16'h0000, 16'h0000, 0, 16'h0001, 1, 0, 0);
        addv("next2",     0, 0, OP_NEXT, 0, 4'b0000, 16'h0000, 16'h0000, 0, 16'h0002, 1, 0, 0);
        addv("next3",     0, 0, OP_NEXT, 0, 4'b0000, 16'h0000, 16'h0000, 0, 16'h0003, 1, 0, 0);
        addv("jump10",    0, 0, OP_JUMP, 0, 4'b0000, 16'h0010, 16'h0000, 1, 16'h0010, 1, 0, 0);
        addv("jmpt_tak",  0, 0, OP_JT,   2, 4'b0100, 16'h0080, 16'h0000, 1, 16'h0080, 1, 0, 0);
        addv("jump10b",   0, 0, OP_JUMP, 0, 4'b0000, 16'h0010, 16'h0000, 1, 16'h0010, 1, 0, 0);
        addv("jmpt_not",  0, 0, OP_JT,   2, 4'b0000, 16'h0080, 16'h0000, 0, 16'h0011, 1, 0, 0);
        addv("jump5",     0, 0, OP_JUMP, 0, 4'b0000, 16'h0005, 16'h0000, 1, 16'h0005, 1, 0, 0);
        addv("call200",   0, 0, OP_CALL, 0, 4'b0000, 16'h0200, 16'h0000, 1, 16'h0200, 1, 0, 1);
        addv("ret",       0, 0, OP_RET,  0, 4'b0000, 16'h0999, 16'h0000, 1, 16'h0006, 1, 0, 0);
        addv("jmpf_tak",  0, 0, OP_JF,   0, 4'b1110, 16'h0030, 16'h0000, 1, 16'h0030, 1, 0, 0);
        addv("jmpf_not",  0, 0, OP_JF,   0, 4'b0001, 16'h0099, 16'h0000, 0, 16'h0031, 1, 0, 0);
        addv("map_stl1",  0, 1, OP_MAP,  0, 4'b0000, 16'h0000, 16'h0340, 2, 16'h0031, 1, 0, 0);
        addv("map_stl2",  0, 1, OP_MAP,  0, 4'b0000, 16'h0000, 16'h0340, 2, 16'h0031, 1, 0, 0);
        addv("map",       0, 0, OP_MAP,  0, 4'b0000, 16'h0000, 16'h0340, 2, 16'h0340, 1, 0, 0);
        addv("jumpffff",  0, 0, OP_JUMP, 0, 4'b0000, 16'hFFFF, 16'h0000, 1, 16'hFFFF, 1, 0, 0);
        addv("halt",      0, 0, OP_HALT, 0, 4'b0000, 16'h0000, 16'h0000, 0, 16'hFFFF, 0, 1, 0);
        addv("halt_stl",  1, 1, OP_NEXT, 0, 4'b0000, 16'h0000, 16'h0000, 0, 16'hFFFF, 0, 1, 0);
        addv("resume",    1, 0, OP_JUMP, 0, 4'b0000, 16'h0123, 16'h0000, 0, 16'h0000, 1, 0, 0);
        addv("start_run", 1, 0, OP_NEXT, 0, 4'b0000, 16'h0000, 16'h0000, 0, 16'h0001, 1, 0, 0);

        foreach (vq[i]) begin
            drive_cycle(vq[i].s, vq[i].stl, vq[i].op, vq[i].cs, vq[i].st, vq[i].ba, vq[i].ma, sel);
            chk({vq[i].name, ".mux_sel"}, sel, vq[i].e_sel);
            chk_state(vq[i].name, vq[i].e_car, vq[i].e_run, vq[i].e_halt, vq[i].e_fault,
                      vq[i].e_depth);
        end

        // Stack overflow: four CALLs fill the stack, the fifth faults with CAR and depth held.
        do_reset();
        drive_cycle(1, 0, OP_NEXT, 0, 0, 16'h0000, 0, sel);
        for (int k = 1; k <= 4; k++) begin
            drive_cycle(0, 0, OP_CALL, 0, 0, 16'(k * 16'h0100), 0, sel);
            chk_state($sformatf("call%0d", k), 16'(k * 16'h0100), 1, 0, 0, 3'(k));
        end
        drive_cycle(0, 0, OP_CALL, 0, 0, 16'h0500, 0, sel);
        chk("ovf.mux_sel", sel, 2'd1);
        chk_state("ovf", 16'h0400, 0, 0, 1, 3'd4);
        drive_cycle(1, 0, OP_JUMP, 0, 0, 16'h0777, 0, sel);
        chk("fault_frozen.mux_sel", sel, 2'd0);
        chk_state("fault_frozen", 16'h0400, 0, 0, 1, 3'd4);

        // Return with an empty stack after a fresh reset.
        do_reset();
        drive_cycle(1, 0, OP_NEXT, 0, 0, 0, 0, sel);
        drive_cycle(0, 0, OP_RET, 0, 0, 16'h0042, 0, sel);
        chk_state("unf", START, 0, 0, 1, 3'd0);

        // Asynchronous reset in the middle of a clock-low phase, with no edge in between.
        do_reset();
        drive_cycle(1, 0, OP_NEXT, 0, 0, 0, 0, sel);
        drive_cycle(0, 0, OP_CALL, 0, 0, 16'h1234, 0, sel);
        chk_state("pre_arst", 16'h1234, 1, 0, 0, 3'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_state("arst", START, 0, 0, 0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_mode = M_IDLE; m_car = START; m_stack.delete();

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [1:0] e_sel;
            if ((m_mode == M_FAULT && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
                do_reset();
            end
            s   = ($urandom_range(0, 3) == 0);
            stl = ($urandom_range(0, 4) == 0);
            op  = 3'($urandom_range(0, 7));
            // Keep HALT and RET rarer so runs reach deeper call nests.
            if (op == OP_HALT && $urandom_range(0, 2) != 0) op = OP_NEXT;
            if (op == OP_RET && $urandom_range(0, 1) != 0) op = OP_CALL;
            cs  = 2'($urandom_range(0, 3));
            st  = 4'($urandom_range(0, 15));
            ba  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            ma  = 16'($urandom);
            e_sel = model_sel(op, cs, st);
            drive_cycle(s, stl, op, cs, st, ba, ma, sel);
            model_step(s, stl, op, cs, st, ba, ma);
            chk("rnd.mux_sel", sel, e_sel);
            chk_state("rnd", m_car, m_mode == M_RUN, m_mode == M_HALT, m_mode == M_FAULT,
                      3'(m_stack.size()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
